// File: rtl/rr_encoder4_2.sv
// Registered 4:2 request encoder with sticky pending bits, round-robin or fixed
// priority selection, and a valid/ready handshake on the encoded index.
module rr_encoder4_2 #(
   parameter bit  RR_EN = 1'b1,
   parameter real DELAY = 0.05
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       ready,
   output logic       valid,
   output logic [1:0] idx,
   output logic [3:0] gnt,
   output logic [3:0] pending
);

   // DELAY only matters to the gate-level datapath models; here it is just range-checked.
   if (DELAY < 0.0) begin : g_bad_delay
      $error("rr_encoder4_2: DELAY must be non-negative");
   end

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [1:0] ptr_q, ptr_d;
   logic [3:0] pending_q, pending_d;

   logic       xfer;
   logic [3:0] clr;
   logic [3:0] avail;
   logic [1:0] base_idle;
   logic [1:0] base_hold;

   // First set bit of mask, searching p, p+1, ... modulo 4.
   function automatic logic [1:0] sel(input logic [3:0] mask, input logic [1:0] p);
      logic [1:0] j;
      sel = p;
      for (int k = 3; k >= 0; k--) begin
         j = p + 2'(k);
         if (mask[j]) sel = j;
      end
   endfunction

   assign valid   = (state_q == StHold);
   assign idx     = idx_q;
   assign pending = pending_q;

   always_comb begin
      xfer      = valid & ready;
      clr       = xfer ? (4'b0001 << idx_q) : 4'b0000;
      avail     = pending_q & ~clr;
      // Set wins over clear: a request landing on its own grant cycle stays pending.
      pending_d = avail | req;
      base_idle = RR_EN ? ptr_q : 2'd0;
      base_hold = RR_EN ? (idx_q + 2'd1) : 2'd0;

      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;

      unique case (state_q)
         StIdle: begin
            if (pending_q != 4'b0000) begin
               state_d = StHold;
               idx_d   = sel(pending_q, base_idle);
            end
         end
         StHold: begin
            if (ready) begin
               if (RR_EN) ptr_d = idx_q + 2'd1;
               if (avail != 4'b0000) begin
                  idx_d = sel(avail, base_hold);
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      gnt = 4'b0000;
      if (valid) gnt = 4'b0001 << idx_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         idx_q     <= 2'd0;
         ptr_q     <= 2'd0;
         pending_q <= 4'b0000;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         pending_q <= pending_d;
      end
   end

endmodule
